led_update_scheduler: RTL and testbench

Controller that sequences readout of the per-LED averaged colour buffer (NUM_LEDS entries of 24-bit RGB, filled by the edge-averaging datapath) toward the LED strip serializer.
- Detects frame boundaries from the pixel counters.
- Runs an update every FRAME_DIV-th frame.
- Streams every LED colour out over a valid/ready handshake.
- Enforces the strip latch gap before the next update can start.

---
 rtl/ambilight_pkg.sv | 15 +
 rtl/led_update_scheduler_if.sv | 29 ++
 rtl/led_update_scheduler_frame_tick_gen.sv | 36 +++
 rtl/led_update_scheduler.sv | 110 +++++++++++
 tb/tb_led_update_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ambilight_pkg.sv
// Types and constants shared by the ambilight LED update path.
package ambilight_pkg;
  typedef logic [23:0] rgb_t;
  typedef logic [7:0]  led_id_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    LATCH
  } sched_state_e;

  localparam led_id_t LED_ID_INVALID = 8'hFF;
endpackage

// File: rtl/led_update_scheduler_if.sv
// Colour buffer read port plus the LED stream toward the strip serializer.
interface led_update_scheduler_if;
  import ambilight_pkg::*;

  logic    buf_rd_en;
  led_id_t buf_rd_id;
  rgb_t    buf_rd_data;

  // LED stream: a transfer happens on a clock edge where led_valid and led_ready
  // are both high; while led_valid waits for led_ready, led_rgb/led_id stay stable.
  logic    led_valid;
  logic    led_ready;
  rgb_t    led_rgb;
  led_id_t led_id;

  modport master (
    output buf_rd_en, buf_rd_id,
    input  buf_rd_data,
    output led_valid, led_rgb, led_id,
    input  led_ready
  );

  modport slave (
    input  buf_rd_en, buf_rd_id,
    output buf_rd_data,
    input  led_valid, led_rgb, led_id,
    output led_ready
  );
endinterface

// File: rtl/led_update_scheduler_frame_tick_gen.sv
// Frame start detection from the pixel counters and the once-per-FRAME_DIV update request.
module frame_tick_gen #(
  parameter int FRAME_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] h_cnt,
  input  logic [15:0] v_cnt,
  input  logic        busy,
  output logic        frame_start,
  output logic        update_req
);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic       at_origin;
  logic       at_origin_q;
  logic [7:0] div_cnt;

  assign at_origin   = (h_cnt == 16'd0) && (v_cnt == 16'd0);
  assign frame_start = at_origin && !at_origin_q;
  assign update_req  = frame_start && !busy && enable && (div_cnt == DIV_LAST);

  // Origin flag resets high so counters parked at 0,0 do not look like a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_origin_q <= 1'b1;
      div_cnt     <= 8'd0;
    end else begin
      at_origin_q <= at_origin;
      if (frame_start && !busy && enable) begin
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/led_update_scheduler.sv
// LED strip update sequencer: reads each averaged colour from the buffer, streams
// it to the serializer and then holds the strip latch gap.
module led_update_scheduler
  import ambilight_pkg::*;
#(
  parameter int NUM_LEDS     = 20,
  parameter int FRAME_DIV    = 2,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            h_cnt,
  input  logic [15:0]            v_cnt,
  led_update_scheduler_if.master bus,
  output logic                   strip_latch,
  output logic                   busy,
  output logic                   update_done,
  output logic                   frame_skipped,
  output sched_state_e           state_dbg
);
  localparam int      LW         = $clog2(LATCH_CYCLES + 1);
  localparam led_id_t LAST_IDX   = led_id_t'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LATCH_INIT = LW'(LATCH_CYCLES - 1);

  sched_state_e  state;
  led_id_t       idx;
  logic [LW-1:0] latch_cnt;
  logic          frame_start;
  logic          update_req;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .busy       (busy),
    .frame_start(frame_start),
    .update_req (update_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      latch_cnt     <= '0;
      bus.buf_rd_en <= 1'b0;
      bus.buf_rd_id <= '0;
      bus.led_valid <= 1'b0;
      bus.led_rgb   <= '0;
      bus.led_id    <= '0;
      strip_latch   <= 1'b0;
      update_done   <= 1'b0;
      frame_skipped <= 1'b0;
    end else begin
      update_done   <= 1'b0;
      // Any frame start outside IDLE, including the final LATCH cycle, is dropped.
      frame_skipped <= frame_start && busy;
      case (state)
        IDLE: begin
          if (update_req) begin
            idx           <= '0;
            bus.buf_rd_en <= 1'b1;
            bus.buf_rd_id <= '0;
            state         <= READ;
          end
        end
        READ: begin
          bus.buf_rd_en <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          bus.led_rgb   <= bus.buf_rd_data;
          bus.led_id    <= idx;
          bus.led_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (bus.led_ready) begin
            bus.led_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              latch_cnt   <= LATCH_INIT;
              strip_latch <= 1'b1;
              state       <= LATCH;
            end else begin
              idx           <= idx + 8'd1;
              bus.buf_rd_en <= 1'b1;
              bus.buf_rd_id <= idx + 8'd1;
              state         <= READ;
            end
          end
        end
        LATCH: begin
          if (latch_cnt == '0) begin
            strip_latch <= 1'b0;
            update_done <= 1'b1;
            state       <= IDLE;
          end else begin
            latch_cnt <= latch_cnt - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_update_scheduler.sv
// Bench for led_update_scheduler: a 4-LED instance for the streaming scenarios and
// a 1-LED, divide-by-1 instance for the minimal update and the LATCH exit skip.
module tb_led_update_scheduler;
  import ambilight_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 2;
  localparam int LAT = 5;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         enable = 1'b1;
  logic [15:0]  h_cnt  = 16'd0;
  logic [15:0]  v_cnt  = 16'd0;
  logic         strip_latch, busy, update_done, frame_skipped;
  sched_state_e state_dbg;
  led_update_scheduler_if bus ();

  logic [15:0]  h_b = 16'd0;
  logic [15:0]  v_b = 16'd0;
  logic         strip_latch_b, busy_b, update_done_b, frame_skipped_b;
  sched_state_e state_b;
  led_update_scheduler_if bus_b ();

  led_update_scheduler #(.NUM_LEDS(N), .FRAME_DIV(DIV), .LATCH_CYCLES(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .h_cnt(h_cnt), .v_cnt(v_cnt), .bus(bus),
    .strip_latch(strip_latch), .busy(busy), .update_done(update_done),
    .frame_skipped(frame_skipped), .state_dbg(state_dbg)
  );

  led_update_scheduler #(.NUM_LEDS(1), .FRAME_DIV(1), .LATCH_CYCLES(LAT)) dut_b (
    .clk(clk), .rst(rst), .enable(1'b1), .h_cnt(h_b), .v_cnt(v_b), .bus(bus_b),
    .strip_latch(strip_latch_b), .busy(busy_b), .update_done(update_done_b),
    .frame_skipped(frame_skipped_b), .state_dbg(state_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1);
  end

  // ---------------- buffer model ----------------
  function automatic rgb_t spec_rgb(input int id);
    return {8'(16 * (id + 1)), 8'h20, 8'h30};
  endfunction

  rgb_t mem [N];
  // Data is only meaningful the cycle after a read strobe; otherwise garbage.
  always @(posedge clk) begin
    bus.buf_rd_data   <= bus.buf_rd_en ? mem[bus.buf_rd_id[1:0]] : rgb_t'($urandom);
    bus_b.buf_rd_data <= bus_b.buf_rd_en ? spec_rgb(0) : rgb_t'($urandom);
  end

  // ---------------- monitor ----------------
  logic [31:0] got_q[$];
  int got_cyc[$];
  int n_latch = 0;
  int n_done  = 0;
  int n_skip  = 0;
  always @(negedge clk) begin
    if (bus.led_valid && bus.led_ready) begin
      got_q.push_back({bus.led_id, bus.led_rgb});
      got_cyc.push_back(cyc);
    end
    if (strip_latch)   n_latch++;
    if (update_done)   n_done++;
    if (frame_skipped) n_skip++;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  int exp_updates = 0;
  int exp_skips   = 0;
  int model_div   = 0;
  int checks      = 0;
  int errors      = 0;
  int g0, e0, d0, u0, s0, k0, l0;

  task automatic mark();
    g0 = got_q.size(); e0 = exp_q.size(); d0 = n_done; u0 = exp_updates;
    s0 = n_skip; k0 = exp_skips; l0 = n_latch;
  endtask

  task automatic model_frame(input bit in_idle, output bit upd);
    upd = 1'b0;
    if (!in_idle) exp_skips++;
    else if (enable) begin
      model_div++;
      if (model_div == DIV) begin
        model_div = 0;
        upd = 1'b1;
        exp_updates++;
        for (int i = 0; i < N; i++) exp_q.push_back({8'(i), mem[i]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    if (h_cnt == 16'd0 && v_cnt == 16'd0) begin
      h_cnt = 16'd7; v_cnt = 16'd3;
      step();
    end
    h_cnt = 16'd0; v_cnt = 16'd0;
    step();
    h_cnt = 16'd7; v_cnt = 16'd3;
  endtask

  task automatic wait_done(input bit rnd);
    int k = 0;
    while (n_done - d0 < exp_updates - u0 && k < 400) begin
      if (rnd) bus.led_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    bus.led_ready = 1'b1;
    if (k >= 400) begin
      checks++; errors++;
      $display("FAIL wait_done timeout got %0d done required %0d", n_done - d0, exp_updates - u0);
    end
  endtask

  task automatic wait_led(input int id);
    int k = 0;
    while (!(bus.led_valid && bus.led_id == 8'(id)) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL wait_led%0d timeout got no valid required led_valid", id);
    end
  endtask

  task automatic frame_idle(input bit rnd);
    bit upd;
    pulse_frame();
    model_frame(1'b1, upd);
    if (upd) wait_done(rnd);
    else repeat (6) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({bus.led_valid, bus.buf_rd_en, strip_latch, busy, update_done, frame_skipped} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000000",
               {bus.led_valid, bus.buf_rd_en, strip_latch, busy, update_done, frame_skipped});
    end
    checks++;
    if ({bus.led_rgb, bus.led_id, bus.buf_rd_id} !== 40'd0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {bus.led_rgb, bus.led_id, bus.buf_rd_id});
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d required %0d", state_dbg, IDLE);
    end
    rst = 1'b0;
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || n_skip !== 0) begin
      errors++; $display("FAIL reset_release got busy=%b skips=%0d required busy=0 skips=0", busy, n_skip);
    end
  endtask

  task automatic test_first_update();
    mark();
    frame_idle(1'b0);
    checks++;
    if (n_done - d0 !== 0 || got_q.size() - g0 !== 0) begin
      errors++; $display("FAIL first_noupdate got %0d leds required 0", got_q.size() - g0);
    end
    frame_idle(1'b0);
    checks++;
    if (got_q.size() - g0 !== exp_q.size() - e0) begin
      errors++; $display("FAIL first_count got %0d required %0d", got_q.size() - g0, exp_q.size() - e0);
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL first_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
    for (int i = 1; i < N && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_cyc[g0 + i] - got_cyc[g0 + i - 1] !== 3) begin
        errors++; $display("FAIL first_spacing%0d got %0d required 3", i, got_cyc[g0 + i] - got_cyc[g0 + i - 1]);
      end
    end
    checks++;
    if (n_latch - l0 !== LAT || n_done - d0 !== 1) begin
      errors++; $display("FAIL first_latch got latch=%0d done=%0d required latch=%0d done=1", n_latch - l0, n_done - d0, LAT);
    end
  endtask

  task automatic test_backpressure();
    bit upd;
    mark();
    frame_idle(1'b0);
    pulse_frame();
    model_frame(1'b1, upd);
    wait_led(2);
    bus.led_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({bus.led_valid, bus.led_rgb, bus.led_id} !== {1'b1, 24'h302030, 8'd2}) begin
        errors++; $display("FAIL bp_hold%0d got %b %h %0d required 1 302030 2", k, bus.led_valid, bus.led_rgb, bus.led_id);
      end
      step();
    end
    bus.led_ready = 1'b1;
    wait_done(1'b0);
    checks++;
    if (got_q.size() - g0 !== exp_q.size() - e0) begin
      errors++; $display("FAIL bp_count got %0d required %0d", got_q.size() - g0, exp_q.size() - e0);
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL bp_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_skip();
    bit upd;
    mark();
    frame_idle(1'b0);
    pulse_frame();
    model_frame(1'b1, upd);
    wait_led(1);
    pulse_frame();
    model_frame(1'b0, upd);
    wait_done(1'b0);
    frame_idle(1'b0);
    checks++;
    if (n_done - d0 !== 1) begin
      errors++; $display("FAIL skip_div got %0d updates required 1", n_done - d0);
    end
    frame_idle(1'b0);
    checks++;
    if (n_skip - s0 !== exp_skips - k0) begin
      errors++; $display("FAIL skip_pulses got %0d required %0d", n_skip - s0, exp_skips - k0);
    end
    checks++;
    if (n_done - d0 !== exp_updates - u0 || n_latch - l0 !== LAT * (exp_updates - u0)) begin
      errors++; $display("FAIL skip_updates got done=%0d latch=%0d required %0d", n_done - d0, n_latch - l0, exp_updates - u0);
    end
    checks++;
    if (got_q.size() - g0 !== exp_q.size() - e0) begin
      errors++; $display("FAIL skip_count got %0d required %0d", got_q.size() - g0, exp_q.size() - e0);
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL skip_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_enable();
    bit upd;
    mark();
    frame_idle(1'b0);
    pulse_frame();
    model_frame(1'b1, upd);
    wait_led(1);
    enable = 1'b0;
    wait_done(1'b0);
    checks++;
    if (got_q.size() - g0 !== N || n_latch - l0 !== LAT) begin
      errors++; $display("FAIL en_complete got leds=%0d latch=%0d required %0d %0d", got_q.size() - g0, n_latch - l0, N, LAT);
    end
    enable = 1'b1;
    frame_idle(1'b0);
    enable = 1'b0;
    repeat (3) frame_idle(1'b0);
    checks++;
    if (n_done - d0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL en_blocked got done=%0d busy=%b required done=1 busy=0", n_done - d0, busy);
    end
    enable = 1'b1;
    frame_idle(1'b0);
    checks++;
    if (n_done - d0 !== exp_updates - u0) begin
      errors++; $display("FAIL en_frozen_div got %0d updates required %0d", n_done - d0, exp_updates - u0);
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL en_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_random();
    mark();
    for (int i = 0; i < N; i++) mem[i] = rgb_t'($urandom);
    repeat (2 * 3) begin
      repeat ($urandom_range(0, 4)) step();
      frame_idle(1'b1);
    end
    checks++;
    if (got_q.size() - g0 !== exp_q.size() - e0 || n_done - d0 !== exp_updates - u0) begin
      errors++; $display("FAIL rand_count got leds=%0d done=%0d required %0d %0d",
                         got_q.size() - g0, n_done - d0, exp_q.size() - e0, exp_updates - u0);
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL rand_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit upd;
    for (int i = 0; i < N; i++) mem[i] = spec_rgb(i);
    mark();
    frame_idle(1'b0);
    pulse_frame();
    model_frame(1'b1, upd);
    wait_led(1);
    bus.led_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.led_valid, busy, strip_latch} !== 3'b000) begin
      errors++; $display("FAIL rst_async got %b required 000", {bus.led_valid, busy, strip_latch});
    end
    // The aborted update delivered only LED 0 and never reaches its latch.
    exp_updates--;
    repeat (N - 1) void'(exp_q.pop_back());
    model_div = 0;
    h_cnt = 16'd0; v_cnt = 16'd0;
    bus.led_ready = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL rst_release got busy=%b state=%0d required 0 %0d", busy, state_dbg, IDLE);
    end
    frame_idle(1'b0);
    frame_idle(1'b0);
    checks++;
    if (got_q.size() - g0 !== exp_q.size() - e0 || n_done - d0 !== exp_updates - u0 ||
        n_latch - l0 !== LAT * (exp_updates - u0)) begin
      errors++; $display("FAIL rst_after got leds=%0d done=%0d latch=%0d required %0d %0d %0d",
                         got_q.size() - g0, n_done - d0, n_latch - l0,
                         exp_q.size() - e0, exp_updates - u0, LAT * (exp_updates - u0));
    end
    for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[g0 + i] !== exp_q[e0 + i]) begin
        errors++; $display("FAIL rst_led%0d got %h required %h", i, got_q[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_single_led();
    sched_state_e seq [9];
    seq = '{READ, WAIT, SEND, LATCH, LATCH, LATCH, LATCH, LATCH, IDLE};
    for (int r = 0; r < 3; r++) begin
      h_b = 16'd7; v_b = 16'd3;
      repeat ($urandom_range(1, 4)) step();
      h_b = 16'd0; v_b = 16'd0;
      step();
      for (int k = 0; k < 9; k++) begin
        if (k == 0 || k == 8) begin h_b = 16'd7; v_b = 16'd3; end
        checks++;
        if (state_b !== seq[k]) begin
          errors++; $display("FAIL one_state r%0d k%0d got %0d required %0d", r, k, state_b, seq[k]);
        end
        if (k == 2) begin
          checks++;
          if ({bus_b.led_valid, bus_b.led_rgb, bus_b.led_id} !== {1'b1, 24'h102030, 8'd0}) begin
            errors++; $display("FAIL one_led r%0d got %b %h %0d required 1 102030 0", r, bus_b.led_valid, bus_b.led_rgb, bus_b.led_id);
          end
        end
        if (k >= 3 && k <= 7) begin
          checks++;
          if (strip_latch_b !== 1'b1) begin
            errors++; $display("FAIL one_latch r%0d k%0d got %b required 1", r, k, strip_latch_b);
          end
        end
        if (k == 8) begin
          checks++;
          if ({update_done_b, frame_skipped_b} !== {1'b1, (r == 2) ? 1'b1 : 1'b0}) begin
            errors++; $display("FAIL one_exit r%0d got done=%b skip=%b required done=1 skip=%0d", r, update_done_b, frame_skipped_b, r == 2);
          end
        end
        // Last round: frame start lands on the final LATCH cycle.
        if (k == 7 && r == 2) begin h_b = 16'd0; v_b = 16'd0; end
        step();
      end
      checks++;
      if (state_b !== IDLE || frame_skipped_b !== 1'b0) begin
        errors++; $display("FAIL one_idle r%0d got state=%0d skip=%b required %0d 0", r, state_b, frame_skipped_b, IDLE);
      end
    end
  endtask

  initial begin
    bus.led_ready   = 1'b1;
    bus_b.led_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = spec_rgb(i);
    test_reset();
    test_first_update();
    test_backpressure();
    test_skip();
    test_enable();
    test_random();
    test_rst_mid();
    test_single_led();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
